bsg_downstream_deser_fifo: RTL

Parametrised downstream channel receiver. It assembles BEATS narrow IO beats into one core word and buffers words in a DEPTH-entry FIFO. It presents them to the core over a valid/ready handshake and returns decimated credit tokens to the upstream sender. It sits between the off-chip IO pins and the core, generalising the fixed 8-bit/2-beat downstream channel to arbitrary width, depth and credit rate, in a single clock domain.

---
 rtl/bsg_ds_pkg.sv | 32 +++
 rtl/bsg_ds_beat_assembler.sv | 49 ++++
 rtl/bsg_downstream_deser_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/bsg_ds_pkg.sv
// Shared constants and width helpers for the downstream deserialising FIFO.
// Holds the default channel geometry and the pointer/counter/token-bit width derivations.
package bsg_ds_pkg;

    localparam int unsigned DEF_IO_W             = 8;
    localparam int unsigned DEF_BEATS            = 4;
    localparam int unsigned DEF_DEPTH            = 16;
    localparam int unsigned DEF_TOKEN_DECIMATION = 4;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of the beat counter; BEATS >= 2 keeps this at least 1.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return clog2(beats);
    endfunction

    // Read-pointer bit that flips once every `dec` dequeues.
    function automatic int unsigned token_bit(input int unsigned dec);
        return clog2(dec);
    endfunction

endpackage

// File: rtl/bsg_ds_beat_assembler.sv
// Collects BEATS narrow IO beats into one core word, first beat in the LSBs.
// The completed word is presented combinationally in the cycle of the final beat.
module bsg_ds_beat_assembler
    import bsg_ds_pkg::*;
#(
    parameter int unsigned IO_W  = DEF_IO_W,
    parameter int unsigned BEATS = DEF_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [IO_W-1:0]       data,
    output logic [IO_W*BEATS-1:0] word,
    output logic                  word_v
);

    localparam int unsigned CNT_W  = beat_cnt_width(BEATS);
    localparam int unsigned PART_W = (BEATS - 1) * IO_W;

    logic [CNT_W-1:0]  cnt;
    logic [PART_W-1:0] partial;
    logic              last;

    always_comb begin
        last   = (cnt == CNT_W'(BEATS - 1));
        word_v = valid & last;
        word   = {data, partial};
    end

    // The final beat is never stored; it is spliced onto the partial word directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            partial <= '0;
        end else if (valid) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            for (int unsigned k = 0; k < BEATS - 1; k++) begin
                if (cnt == CNT_W'(k)) begin
                    partial[k*IO_W +: IO_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_downstream_deser_fifo.sv
// Downstream channel receiver: beat assembly, DEPTH-entry fall-through FIFO, decimated credit token.
// Define BSG_DS_OVERFLOW_CHECK_EN to add the sticky overflow_o flag for refused enqueues.
module bsg_downstream_deser_fifo
    import bsg_ds_pkg::*;
#(
    parameter int unsigned IO_W             = DEF_IO_W,
    parameter int unsigned BEATS            = DEF_BEATS,
    parameter int unsigned DEPTH            = DEF_DEPTH,
    parameter int unsigned TOKEN_DECIMATION = DEF_TOKEN_DECIMATION
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    io_valid_i,
    input  logic [IO_W-1:0]         io_data_i,
    output logic                    io_token_o,
    output logic                    core_v_o,
    output logic [IO_W*BEATS-1:0]   core_data_o,
    input  logic                    core_ready_i,
    output logic [clog2(DEPTH):0]   count_o
`ifdef BSG_DS_OVERFLOW_CHECK_EN
    ,
    output logic                    overflow_o
`endif
);

    localparam int unsigned ADDR_W  = clog2(DEPTH);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned WORD_W  = IO_W * BEATS;
    localparam int unsigned TOK_BIT = token_bit(TOKEN_DECIMATION);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  rptr_next;
    logic [WORD_W-1:0] word;
    logic              word_v;
    logic              empty;
    logic              full;
    logic              deq;
    logic              enq;

    bsg_ds_beat_assembler #(
        .IO_W  (IO_W),
        .BEATS (BEATS)
    ) assembler (
        .clk    (clk),
        .rst    (rst),
        .valid  (io_valid_i),
        .data   (io_data_i),
        .word   (word),
        .word_v (word_v)
    );

    always_comb begin
        empty       = (wptr == rptr);
        full        = (wptr[ADDR_W] != rptr[ADDR_W])
                   && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
        core_v_o    = !empty;
        core_data_o = mem[rptr[ADDR_W-1:0]];
        deq         = core_v_o & core_ready_i;
        // A dequeue in the same cycle frees the slot, so a full FIFO still accepts.
        enq         = word_v & (!full | deq);
        rptr_next   = deq ? rptr + PTR_W'(1) : rptr;
        count_o     = wptr - rptr;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr[ADDR_W-1:0]] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            io_token_o <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr       <= rptr_next;
            io_token_o <= rptr_next[TOK_BIT];
        end
    end

`ifdef BSG_DS_OVERFLOW_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (word_v & !enq) begin
            overflow_o <= 1'b1;
        end
    end
`endif

endmodule
